// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue
// Decoupled instruction prefetch engine. It issues sequential fetch
// addresses on an SRAM-like bus (req / addr_ok / data_ok), keeps up to
// MAX_OUTSTANDING accepted requests in flight, and buffers returned
// instructions in a DEPTH-entry FIFO toward decode. A redirect flushes the
// FIFO, marks every in-flight or pending response as stale and restarts
// fetch at redirect_pc.
//
// Ports
//   clk, reset               clock, async active-high reset
//   redirect, redirect_pc    flush and restart fetch
//   inst_req, inst_addr      registered bus request / address
//   inst_addr_ok             request accepted this cycle
//   inst_data_ok, inst_rdata in-order read data return
//   out_valid, out_ready     head handshake toward decode
//   out_pc, out_inst         head PC / instruction (inst is 0 on exception)
//   out_exc, out_exccode     fetch exception flag / code (AdEL = 5'h04)
module if_prefetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_exc,
   output logic [4:0]  out_exccode
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 2);
   localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic [CW-1:0] outst_q, outst_d, stale_q, stale_d, live_d;
   logic          halted_q, halted_d;
   logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_cnt, cnt_d;
   logic [31:0]   fpc_q   [DEPTH];
   logic [31:0]   finst_q [DEPTH];
   logic          fexc_q  [DEPTH];
   logic [31:0]   trk_pc_q [MAX_OUTSTANDING];
   logic [TW-1:0] trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;

   logic        accept, pending_nxt, ret_stale, data_push, exc_push, push, pop;
   logic        can_issue;
   logic [31:0] issue_pc, push_pc, push_inst;

   always_comb begin
      accept      = req_q & inst_addr_ok;
      pending_nxt = req_q & ~inst_addr_ok;
      ret_stale   = inst_data_ok & (stale_q != '0);
      fifo_cnt    = wr_ptr_q - rd_ptr_q;
      pop         = (fifo_cnt != '0) & out_ready & ~redirect;
      data_push   = inst_data_ok & ~ret_stale & ~redirect;
      // Misaligned PC becomes an AdEL entry instead of a bus request.
      exc_push    = ~redirect & ~halted_q & (fetch_pc_q[1:0] != 2'b00) &
                    ~data_push & (32'(fifo_cnt) < DEPTH);
      push        = data_push | exc_push;
      push_pc     = exc_push ? fetch_pc_q : trk_pc_q[trk_rd_q];
      push_inst   = exc_push ? 32'h0 : inst_rdata;

      outst_d = outst_q + CW'(accept) - CW'(inst_data_ok);
      // On redirect everything in flight, plus a request still waiting for
      // addr_ok, will return data that must be dropped.
      if (redirect) begin
         stale_d = outst_d + CW'(pending_nxt);
      end else begin
         stale_d = stale_q - CW'(ret_stale);
      end
      live_d = outst_d - stale_d;
      cnt_d  = redirect ? '0 : fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);

      // Issue is judged on post-edge occupancy: the new request must still
      // fit in the FIFO after every live response has landed.
      issue_pc  = redirect ? redirect_pc : fetch_pc_q;
      can_issue = ~pending_nxt & (issue_pc[1:0] == 2'b00) & (redirect | ~halted_q) &
                  (32'(cnt_d) + 32'(live_d) + 32'd1 <= DEPTH) &
                  (32'(outst_d) + 32'd1 <= MAX_OUTSTANDING);

      req_d      = can_issue | pending_nxt;
      addr_d     = can_issue ? issue_pc : addr_q;
      fetch_pc_d = can_issue ? issue_pc + 32'd4 : issue_pc;
      halted_d   = ~redirect & (halted_q | exc_push);

      wr_ptr_d = redirect ? '0 : wr_ptr_q + (PW+1)'(push);
      rd_ptr_d = redirect ? '0 : rd_ptr_q + (PW+1)'(pop);

      trk_wr_d = trk_wr_q;
      if (accept) begin
         trk_wr_d = (trk_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : trk_wr_q + TW'(1);
      end
      trk_rd_d = trk_rd_q;
      if (inst_data_ok) begin
         trk_rd_d = (trk_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : trk_rd_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         outst_q    <= '0;
         stale_q    <= '0;
         halted_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         trk_wr_q   <= '0;
         trk_rd_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fpc_q[i]   <= '0;
            finst_q[i] <= '0;
            fexc_q[i]  <= 1'b0;
         end
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            trk_pc_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         outst_q    <= outst_d;
         stale_q    <= stale_d;
         halted_q   <= halted_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         trk_wr_q   <= trk_wr_d;
         trk_rd_q   <= trk_rd_d;
         if (push) begin
            fpc_q[wr_ptr_q[PW-1:0]]   <= push_pc;
            finst_q[wr_ptr_q[PW-1:0]] <= push_inst;
            fexc_q[wr_ptr_q[PW-1:0]]  <= exc_push;
         end
         if (accept) begin
            trk_pc_q[trk_wr_q] <= addr_q;
         end
      end
   end

   assign inst_req    = req_q;
   assign inst_addr   = addr_q;
   assign out_valid   = (fifo_cnt != '0);
   assign out_pc      = out_valid ? fpc_q[rd_ptr_q[PW-1:0]] : 32'h0;
   assign out_inst    = out_valid ? finst_q[rd_ptr_q[PW-1:0]] : 32'h0;
   assign out_exc     = out_valid & fexc_q[rd_ptr_q[PW-1:0]];
   assign out_exccode = out_exc ? 5'h04 : 5'h00;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue. Acts as the instruction bus (in-order
// returns, content derived from the address) and as decode, and compares
// every popped entry with the expected sequential PC stream.
module tb_if_prefetch_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;
   localparam logic [31:0] RPC   = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc, out_inst;
   logic        out_exc;
   logic [4:0]  out_exccode;

   if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
      .out_exccode(out_exccode)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_err = 0;
   int          aok_mode = 0, dok_mode = 0, rdy_mode = 0;   // 0 low, 1 high, 2 random
   logic        redir_now = 1'b0;
   logic [31:0] redir_pc_v = '0;
   logic [31:0] bus_q [$];
   logic [31:0] exp_req_pc = RPC, exp_out_pc = RPC, prev_addr = '0;
   logic        prev_pend = 1'b0;
   int          n_issue = 0, n_pop = 0, acc_total = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9e3779b1) ^ 32'h5ca1ab1e;
   endfunction

   function automatic logic pick(input int mode);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return ($urandom_range(0, 3) != 0);
   endfunction

   // One bus/decode cycle: observe at negedge, decide what happens at the
   // coming posedge, update the reference, drive inputs.
   task automatic cycle();
      logic        a, d, r, red;
      logic [31:0] rpc, rd_v;
      logic [1:0]  lo;
      @(negedge clk);
      if (prev_pend) begin
         chk("req_hold", inst_req, 1'b1);
         chk("addr_hold", inst_addr, prev_addr);
      end else if (inst_req) begin
         chk("req_addr", inst_addr, exp_req_pc);
         exp_req_pc += 32'd4;
         n_issue++;
      end
      a   = pick(aok_mode);
      d   = (bus_q.size() > 0) && pick(dok_mode);
      r   = pick(rdy_mode);
      red = redir_now;
      rpc = redir_pc_v;
      redir_now = 1'b0;
      rd_v = $urandom;
      if (inst_req && a) begin
         chk("max_outstanding", 32'(bus_q.size() < MAXO), 32'd1);
      end
      if (d) rd_v = mem(bus_q.pop_front());
      if (inst_req && a) begin
         bus_q.push_back(inst_addr);
         acc_total++;
      end
      if (out_valid && r && !red) begin
         lo = exp_out_pc[1:0];
         chk("out_pc", out_pc, exp_out_pc);
         if (lo != 2'b00) begin
            chk("out_exc", out_exc, 1'b1);
            chk("out_exccode", out_exccode, 5'h04);
            chk("out_inst_exc", out_inst, 32'h0);
         end else begin
            chk("out_exc", out_exc, 1'b0);
            chk("out_exccode", out_exccode, 5'h00);
            chk("out_inst", out_inst, mem(exp_out_pc));
         end
         exp_out_pc += 32'd4;
         n_pop++;
      end
      if (red) begin
         exp_out_pc = rpc;
         exp_req_pc = rpc;
      end
      prev_pend    = inst_req && !a;
      prev_addr    = inst_addr;
      inst_addr_ok = a;
      inst_data_ok = d;
      inst_rdata   = rd_v;
      out_ready    = r;
      redirect     = red;
      redirect_pc  = red ? rpc : $urandom;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, inst_req, 1'b0);
      chk({tag, "_addr"}, inst_addr, RPC);
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_pc"}, out_pc, 32'h0);
      chk({tag, "_inst"}, out_inst, 32'h0);
      chk({tag, "_exc"}, out_exc, 1'b0);
      chk({tag, "_code"}, out_exccode, 5'h00);
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redir_now  = 1'b1;
      redir_pc_v = pc;
      cycle();
   endtask

   task automatic wait_valid(input string tag);
      int i = 0;
      do begin
         cycle();
         i++;
      end while (!out_valid && i < 80);
      chk({tag, "_timeout"}, out_valid, 1'b1);
   endtask

   initial begin
      int p, iss, i;
      logic [31:0] old_addr, rpc;

      // reset values
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;

      // sustained one-per-cycle fetch
      aok_mode = 1; dok_mode = 1; rdy_mode = 1;
      repeat (6) cycle();
      p = n_pop;
      repeat (16) cycle();
      chk("throughput", 32'(n_pop - p), 32'd16);

      // decode stalled: exactly DEPTH entries buffered, fetch stops
      rdy_mode = 0;
      repeat (12) cycle();
      chk("fill_count", 32'(acc_total - bus_q.size() - n_pop), DEPTH);
      chk("fill_no_req", inst_req, 1'b0);
      chk("fill_outst", 32'(bus_q.size()), 32'd0);
      rdy_mode = 1;
      iss = n_issue;
      for (i = 0; i < 20 && n_issue == iss; i++) cycle();
      chk("fill_resume", 32'(n_issue > iss), 32'd1);
      repeat (4) cycle();

      // redirect with two responses outstanding
      dok_mode = 0;
      for (i = 0; i < 40 && !(bus_q.size() == 2 && !out_valid && !inst_req); i++) cycle();
      chk("two_outst_timeout", 32'(bus_q.size()), 32'd2);
      do_redirect(32'hbfc00100);
      dok_mode = 1;
      wait_valid("redir1");
      chk("redir1_pc", out_pc, 32'hbfc00100);
      chk("redir1_inst", out_inst, mem(32'hbfc00100));
      repeat (6) cycle();

      // redirect while a request waits for addr_ok
      aok_mode = 0;
      for (i = 0; i < 40 && !(inst_req && bus_q.size() == 0); i++) cycle();
      chk("pend_timeout", inst_req, 1'b1);
      old_addr = inst_addr;
      do_redirect(32'hbfc00200);
      repeat (3) cycle();
      chk("pend_addr_stable", inst_addr, old_addr);
      aok_mode = 1;
      wait_valid("redir2");
      chk("redir2_pc", out_pc, 32'hbfc00200);
      chk("redir2_inst", out_inst, mem(32'hbfc00200));
      repeat (6) cycle();

      // misaligned redirect target
      do_redirect(32'hbfc00102);
      wait_valid("mis");
      chk("mis_pc", out_pc, 32'hbfc00102);
      chk("mis_exc", out_exc, 1'b1);
      chk("mis_code", out_exccode, 5'h04);
      chk("mis_inst", out_inst, 32'h0);
      iss = n_issue;
      repeat (10) cycle();
      chk("mis_halt_no_fetch", 32'(n_issue - iss), 32'd0);
      chk("mis_halt_empty", out_valid, 1'b0);
      do_redirect(32'hbfc00300);

      // randomized bus, decode and redirects
      aok_mode = 2; dok_mode = 2; rdy_mode = 2;
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 49) == 0) begin
            rpc = 32'hbfc00000 + ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 7) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            redir_now  = 1'b1;
            redir_pc_v = rpc;
         end
         cycle();
      end
      aok_mode = 1; dok_mode = 1; rdy_mode = 1;
      do_redirect(32'hbfc00400);
      repeat (30) cycle();

      // reset in the middle of traffic with a partly full FIFO
      rdy_mode = 0;
      repeat (2) cycle();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_outputs("midrst");
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; out_ready = 1'b0; redirect = 1'b0;
      bus_q.delete();
      prev_pend  = 1'b0;
      exp_req_pc = RPC;
      exp_out_pc = RPC;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      rdy_mode = 1;
      iss = n_issue;
      for (i = 0; i < 10 && n_issue == iss; i++) cycle();
      chk("midrst_first_fetch", 32'(n_issue - iss), 32'd1);
      chk("midrst_first_addr", inst_addr, RPC);
      repeat (20) cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-PC fetch path with a decoupled prefetch engine. It generates sequential fetch addresses, issues them on the SRAM-like instruction bus (req/addr_ok/data_ok), tracks multiple outstanding requests, and buffers returned instructions in a DEPTH-entry FIFO toward decode. Redirects from branch or exception commit flush the queue and discard in-flight responses. It sits between the instruction bus and the decode stage.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, max accepted-but-not-returned bus requests (>=1)
RESET_PC, 32'hbfc00000, fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
redirect  in  1  flush and restart fetch at redirect_pc (branch/commit/eret)
redirect_pc  in  32  new fetch address
inst_req  out  1  bus request
inst_addr  out  32  bus request address
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle (in-order returns)
inst_rdata  in  32  read data
out_valid  out  1  head entry valid toward decode
out_ready  in  1  decode accepts head
out_pc  out  32  head PC
out_inst  out  32  head instruction (0 when out_exc)
out_exc  out  1  head carries fetch exception
out_exccode  out  5  5'h04 (AdEL) when out_exc, else 0

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, FIFO empty, out_valid=0, out_pc=0, out_inst=0, out_exc=0, out_exccode=0, outstanding=0, stale=0, halted=0.
- inst_req/inst_addr are registered. A request, once raised, holds inst_addr stable until inst_addr_ok; it is never withdrawn, including on redirect.
- Issue condition (evaluated each cycle, request raised next edge): !inst_req or (inst_req && inst_addr_ok), fetch_pc[1:0]==0, !halted, fifo_count+live_outstanding+pending_req < DEPTH, outstanding+pending_req < MAX_OUTSTANDING. pending_req = inst_req && !inst_addr_ok. On issue: inst_addr<=fetch_pc, fetch_pc<=fetch_pc+4. Back-to-back issue every cycle permitted when addr_ok is high.
- Accept (inst_req && inst_addr_ok): outstanding+1; the address is pushed into a MAX_OUTSTANDING-deep in-flight PC tracker.
- Return (inst_data_ok): outstanding-1; pop tracker. If stale>0, stale-1 and data discarded; else write {pc, inst_rdata, exc=0} into FIFO. Written entry is visible at head no earlier than the next cycle (no bypass).
- Misaligned fetch_pc (bits[1:0]!=0) and !halted and FIFO space: no bus request; enqueue {fetch_pc, 0, exc=1, code=5'h04} and set halted=1. Halted clears only on redirect or reset.
- Pop: out_valid && out_ready removes head. Simultaneous push and pop on a full FIFO is legal; count unchanged.
- Redirect (one cycle): FIFO emptied, out_valid=0 next cycle; stale <= outstanding + (accept this cycle) - (non-stale/stale return this cycle) plus 1 if a request is still pending (it becomes stale on acceptance); fetch_pc<=redirect_pc; halted<=0. data_ok in the redirect cycle is discarded. A pop in the redirect cycle is ignored. First new request appears the cycle after redirect if no pending request, otherwise the cycle after the pending one is accepted. New responses are written only after stale reaches 0.
- Redirect has priority over issue, push and pop in the same cycle.
- Counters: outstanding and stale are clog2(MAX_OUTSTANDING+2) bits; must never underflow; fifo pointers wrap modulo DEPTH with an extra bit for full/empty.
- Reset asserted mid-transaction: all state cleared; responses arriving after reset deassertion for pre-reset requests are the bus's responsibility (bus is reset together).

Test Plan:
- Reset, addr_ok=data_ok=1 (one-cycle latency), out_ready=1 -> inst_addr 0xbfc00000, 0xbfc00004, ... one per cycle; out_pc sequence matches with one instruction per cycle sustained.
- out_ready=0, bus always ready -> exactly DEPTH=4 entries queued, no further inst_req beyond space; then out_ready=1 -> 4 pops in order, fetching resumes.
- Two requests outstanding (data_ok held low), redirect to 0xbfc00100 -> both old responses discarded, first out_pc=0xbfc00100 with correct data.
- inst_req pending with addr_ok=0 when redirect arrives -> inst_addr stays stable until addr_ok; its response is discarded; next request addr 0xbfc00200.
- Redirect to 0xbfc00102 -> no bus request; out_valid with out_pc=0xbfc00102, out_exc=1, out_exccode=5'h04; no further fetch until next redirect.
- Assert reset with requests in flight and FIFO half full -> all outputs return to reset values immediately; after release first inst_addr=0xbfc00000.
